// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared IEEE-754 binary32 constants, types and the operand
//            unpack/classify helper used by the adder datapath.
// Contents : EXP_W, MAN_W, BIAS, EXP_MAX, QNAN, POS_INF, NEG_INF,
//            fp32_t (raw packed word), fp_op_t (unpacked operand),
//            fp_unpack() (raw word -> unpacked operand).
// Revision : 1.0  initial release
// ============================================================================
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // All-ones exponent field: reserved for Inf/NaN, and the overflow threshold.
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  // exp is the effective exponent (subnormals read as 1); sig carries the
  // explicit hidden bit in its MSB.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_op_t;

  function automatic fp_op_t fp_unpack(input fp32_t x);
    fp_op_t op;
    logic   exp_zero;
    logic   exp_ones;
    logic   frac_zero;
    exp_zero   = (x.exp == '0);
    exp_ones   = (x.exp == EXP_MAX);
    frac_zero  = (x.frac == '0);
    op.sign    = x.sign;
    op.exp     = exp_zero ? EXP_W'(1) : x.exp;
    op.sig     = {~exp_zero, x.frac};
    op.is_zero = exp_zero & frac_zero;
    op.is_inf  = exp_ones & frac_zero;
    op.is_nan  = exp_ones & ~frac_zero;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Purpose  : Leading-zero counter over the 27-bit post-add significand
//            {hidden+fraction, guard, round, sticky}.
// Ports    : i_data  in  27  value to scan, MSB first
//            o_count out  5  number of leading zeros (27 when i_data == 0)
// Revision : 1.0  initial release
// ============================================================================
module fp_lzc (
  input  logic [26:0] i_data,
  output logic [4:0]  o_count
);

  // Ascending scan: the highest set bit is visited last and therefore wins.
  always_comb begin
    o_count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (i_data[i]) begin
        o_count = 5'(26 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
// ============================================================================
// Module   : add
// Purpose  : IEEE-754 binary32 adder, round-to-nearest-even, one output
//            register (latency 1, throughput 1 per cycle). Subtraction is
//            done by the caller flipping b[31].
// Ports    : clk     in   1  clock, rising edge
//            rst_n   in   1  asynchronous active-low reset
//            a       in  32  operand A {sign, exp[7:0], frac[22:0]}
//            b       in  32  operand B
//            result  out 32  registered a + b
// Revision : 1.0  initial release
// ============================================================================
module add
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // ---------------------------------------------------------------- unpack
  fp_op_t w_ua;
  fp_op_t w_ub;
  assign w_ua = fp_unpack(fp32_t'(a));
  assign w_ub = fp_unpack(fp32_t'(b));

  // ------------------------------------------------------------ swap/align
  // {exp,frac} compares as an unsigned magnitude, so the raw fields order
  // the operands directly.
  logic   w_a_ge_b;
  fp_op_t w_l;
  fp_op_t w_s;
  assign w_a_ge_b = (a[30:0] >= b[30:0]);
  assign w_l      = w_a_ge_b ? w_ua : w_ub;
  assign w_s      = w_a_ge_b ? w_ub : w_ua;

  logic [7:0]  w_exp_diff;
  logic [4:0]  w_shamt;
  logic [49:0] w_s_wide;
  logic [26:0] w_s_al;
  logic [26:0] w_l_al;

  assign w_exp_diff = w_l.exp - w_s.exp;
  // Any shift of 26 or more pushes the whole significand into sticky, so
  // clamping at 26 keeps the shifter narrow without changing the result.
  assign w_shamt    = (w_exp_diff > 8'd26) ? 5'd26 : w_exp_diff[4:0];
  assign w_s_wide   = {w_s.sig, 26'd0} >> w_shamt;
  // Layout: {24-bit significand, guard, round, sticky}.
  assign w_s_al     = {w_s_wide[49:24], |w_s_wide[23:0]};
  assign w_l_al     = {w_l.sig, 3'b000};

  // --------------------------------------------------------------- add/sub
  logic        w_eff_sub;
  logic [27:0] w_sum;
  logic [26:0] w_m;
  logic [9:0]  w_e;

  assign w_eff_sub = w_ua.sign ^ w_ub.sign;
  // The larger magnitude is always on the left, so subtraction never borrows.
  assign w_sum = w_eff_sub ? ({1'b0, w_l_al} - {1'b0, w_s_al})
                           : ({1'b0, w_l_al} + {1'b0, w_s_al});
  // Carry-out: shift right one, folding the dropped bit into sticky.
  assign w_m   = w_sum[27] ? {w_sum[27:2], w_sum[1] | w_sum[0]} : w_sum[26:0];
  assign w_e   = {2'b00, w_l.exp} + {9'd0, w_sum[27]};

  // ------------------------------------------------------------- normalise
  logic [4:0] w_lz;
  logic [9:0] w_lz10;
  logic [9:0] w_max_sh;
  logic [9:0] w_nshift;
  logic [26:0] w_mn;
  logic [9:0]  w_en;

  fp_lzc u_lzc (
    .i_data  (w_m),
    .o_count (w_lz)
  );

  assign w_lz10   = {5'd0, w_lz};
  // The exponent may not drop below 1; stopping early leaves the hidden bit
  // clear, which is exactly a subnormal (gradual underflow).
  assign w_max_sh = w_e - 10'd1;
  assign w_nshift = (w_lz10 > w_max_sh) ? w_max_sh : w_lz10;
  assign w_mn     = w_m << w_nshift;
  assign w_en     = w_e - w_nshift;

  // ----------------------------------------------------------------- round
  logic        w_inc;
  logic [24:0] w_rnd;
  logic [9:0]  w_exp_fin;
  logic [22:0] w_frac_fin;

  assign w_inc = w_mn[2] & (w_mn[1] | w_mn[0] | w_mn[3]);
  assign w_rnd = {1'b0, w_mn[26:3]} + {24'd0, w_inc};
  // rnd[24]: rounding overflowed the significand -> exp+1.
  // rnd[23]: value is normal (possibly promoted from subnormal by the carry,
  //          in which case w_en is already 1).
  // neither: subnormal, exponent field 0.
  assign w_exp_fin  = w_rnd[24] ? (w_en + 10'd1) : (w_rnd[23] ? w_en : 10'd0);
  assign w_frac_fin = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

  // ------------------------------------------------------ special-case mux
  logic        w_zero_sign;
  logic        w_any_nan;
  logic        w_inf_clash;
  logic [31:0] w_next;

  // A zero sum is -0 only when both inputs are -0; cancellation gives +0.
  assign w_zero_sign = w_ua.is_zero & w_ub.is_zero & w_ua.sign & w_ub.sign;
  assign w_any_nan   = w_ua.is_nan | w_ub.is_nan;
  assign w_inf_clash = w_ua.is_inf & w_ub.is_inf & w_eff_sub;

  always_comb begin
    w_next = {w_l.sign, w_exp_fin[7:0], w_frac_fin};
    if (w_any_nan || w_inf_clash) begin
      w_next = QNAN;
    end else if (w_ua.is_inf) begin
      w_next = w_ua.sign ? NEG_INF : POS_INF;
    end else if (w_ub.is_inf) begin
      w_next = w_ub.sign ? NEG_INF : POS_INF;
    end else if (w_m == 27'd0) begin
      w_next = {w_zero_sign, 31'd0};
    end else if (w_exp_fin >= {2'b00, EXP_MAX}) begin
      w_next = w_l.sign ? NEG_INF : POS_INF;
    end
  end

  // ------------------------------------------------------- output register
  logic [31:0] r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 32'd0;
    end else begin
      r_result <= w_next;
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_add
// Purpose  : Directed self-checking bench for the binary32 adder.
// Revision : 1.0  initial release
// ============================================================================
module tb_add;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  add dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
  endtask

  // Present one operand pair; it is sampled at the next rising edge and the
  // registered sum is checked just after that edge.
  task automatic step(input string tag, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] expv);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check(tag, result, expv);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with nonzero operands.
    #2;
    a     = 32'h3F80_0000;
    b     = 32'h4000_0000;
    rst_n = 1'b0;
    #1;
    check("rst_async", result, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rst_hold", result, 32'h0000_0000);

    // Release with zero operands.
    @(negedge clk);
    a     = 32'd0;
    b     = 32'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release", result, 32'h0000_0000);

    // Back-to-back vectors, one per cycle.
    step("add_basic",    32'h411C_0000, 32'h3F10_0000, 32'h4125_0000);
    step("add_swapped",  32'h3F10_0000, 32'h411C_0000, 32'h4125_0000);
    step("sub_basic",    32'h411C_0000, 32'hBF10_0000, 32'h4113_0000);
    step("sticky_lost",  32'hB000_0000, 32'hC000_0000, 32'hC000_0000);
    step("tie_even",     32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    step("tie_odd",      32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    step("sub_renorm",   32'h3F80_0000, 32'hB380_0000, 32'h3F7F_FFFF);
    step("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    step("cancel_zero",  32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    step("nz_plus_nz",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    step("pz_plus_nz",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    step("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    step("inf_clash",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    step("nan_in",       32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
    step("ninf_finite",  32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000);
    step("inf_same",     32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
    step("sub_plus_sub", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
    step("norm_to_sub",  32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF);
    step("sub_to_norm",  32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000);

    // Reset mid-stream discards the in-flight sum.
    a = 32'h411C_0000;
    b = 32'h3F10_0000;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_midstream", result, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rst_mid_hold", result, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset",  32'h411C_0000, 32'hBF10_0000, 32'h4113_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
